// File: rtl/sample_i2s_tx.sv
// Mono sample FIFO feeding a left-justified I2S-style serialiser; the same sample goes out in both slots.
// o_bclk is generated as registered data from i_clk48, not as a clock.
//   state | meaning
//   IDLE  | serial outputs held low, waiting for FIFO to reach START_LVL
//   RUN   | 64-bit frames being shifted out, one sample per frame
module sample_i2s_tx #(
  parameter int DEPTH     = 16,
  parameter int START_LVL = 8,
  parameter int PAUSE_LVL = 12,
  parameter int BCLK_HALF = 8
) (
  input  logic        i_clk48,
  input  logic        i_rst48_n,
  input  logic [15:0] i_sample,
  input  logic        i_pulse,
  input  logic        i_clr_err,
  output logic        o_pause,
  output logic        o_bclk,
  output logic        o_lrck,
  output logic        o_sdata,
  output logic [4:0]  o_level,
  output logic        o_overflow,
  output logic        o_underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [4:0]    FULL_L  = 5'(DEPTH);
  localparam logic [4:0]    START_L = 5'(START_LVL);
  localparam logic [4:0]    PAUSE_L = 5'(PAUSE_LVL);
  localparam logic [DW-1:0] DIV_TC  = DW'(BCLK_HALF - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nx;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [15:0]     cur, cur_nx, head;
  logic [DW-1:0]   div, div_nx;
  logic [5:0]      b, b_nx;
  logic            bclk_nx, lrck_nx, sdata_nx;
  logic            pop, push, drop, underrun_set;

  // Frame bit: MSB-first in the first 16 bits of each 32-bit slot, zero padding after.
  function automatic logic frame_bit(input logic [15:0] s, input logic [5:0] idx);
    frame_bit = idx[4] ? 1'b0 : s[4'd15 - idx[3:0]];
  endfunction

  assign head = mem[rd_ptr];
  assign push = i_pulse && ((o_level < FULL_L) || pop);
  assign drop = i_pulse && !push;

  always_ff @(posedge i_clk48) begin
    if (!i_rst48_n) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    div_nx       = div;
    b_nx         = b;
    cur_nx       = cur;
    bclk_nx      = o_bclk;
    lrck_nx      = o_lrck;
    sdata_nx     = o_sdata;
    pop          = 1'b0;
    underrun_set = 1'b0;
    case (state)
      IDLE: begin
        div_nx   = '0;
        b_nx     = '0;
        bclk_nx  = 1'b0;
        lrck_nx  = 1'b0;
        sdata_nx = 1'b0;
        if (o_level >= START_L) begin
          state_nx = RUN;
          pop      = 1'b1;
          cur_nx   = head;
          sdata_nx = frame_bit(head, 6'd0);
        end
      end
      RUN: begin
        if (div == DIV_TC) begin
          div_nx  = '0;
          bclk_nx = ~o_bclk;
          if (o_bclk) begin
            b_nx = b + 6'd1;
            if (b == 6'd63) begin
              if (o_level != 5'd0) begin
                pop      = 1'b1;
                cur_nx   = head;
                lrck_nx  = 1'b0;
                sdata_nx = frame_bit(head, 6'd0);
              end else begin
                underrun_set = 1'b1;
                state_nx     = IDLE;
                bclk_nx      = 1'b0;
                lrck_nx      = 1'b0;
                sdata_nx     = 1'b0;
              end
            end else begin
              lrck_nx  = b_nx[5];
              sdata_nx = frame_bit(cur, b_nx);
            end
          end
        end else begin
          div_nx = div + DW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk48) begin
    if (push) mem[wr_ptr] <= i_sample;
  end

  always_ff @(posedge i_clk48) begin
    if (!i_rst48_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_level    <= '0;
      o_pause    <= 1'b0;
      cur        <= '0;
      div        <= '0;
      b          <= '0;
      o_bclk     <= 1'b0;
      o_lrck     <= 1'b0;
      o_sdata    <= 1'b0;
      o_overflow <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   o_level <= o_level + 5'd1;
        2'b01:   o_level <= o_level - 5'd1;
        default: o_level <= o_level;
      endcase
      o_pause <= (o_level >= PAUSE_L);
      cur     <= cur_nx;
      div     <= div_nx;
      b       <= b_nx;
      o_bclk  <= bclk_nx;
      o_lrck  <= lrck_nx;
      o_sdata <= sdata_nx;
      // A new error event wins over a clear arriving in the same cycle.
      if (drop)           o_overflow <= 1'b1;
      else if (i_clr_err) o_overflow <= 1'b0;
      if (underrun_set)   o_underrun <= 1'b1;
      else if (i_clr_err) o_underrun <= 1'b0;
    end
  end

endmodule
